// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: splits one 32-bit MEM-stage load/store into two 16-bit
// asynchronous SRAM half-accesses (low half first), holding the pipeline with
// freeze until the access completes and pulsing ready for one cycle.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; op/address/wdata latched on acceptance
// LOW   | half-access 0 (sram_addr bit 0 = 0), WAIT_CYCLES cycles
// HIGH  | half-access 1 (sram_addr bit 0 = 1), WAIT_CYCLES cycles
// DONE  | one-cycle completion, ready=1, freeze released
module mem_access_ctrl #(
  parameter int WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        freeze,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        op_wr;
  logic [16:0] addr_q;
  logic [31:0] wdata_q;
  logic        req;
  logic        last;
  logic        half;

  // Address bits outside [18:2] play no part in the SRAM address.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{address[31:19], address[1:0]};

  assign req  = mem_r_en | mem_w_en;
  assign last = (cnt == CNT_LAST);
  assign half = (state == HIGH);

  // State and wait-counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        cnt_nx = 4'd0;
        if (req) state_nx = LOW;
      end
      LOW: begin
        if (last) begin
          state_nx = HIGH;
          cnt_nx   = 4'd0;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      HIGH: begin
        if (last) begin
          state_nx = DONE;
          cnt_nx   = 4'd0;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      DONE: begin
        state_nx = IDLE;
        cnt_nx   = 4'd0;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  // Latch the operation on acceptance; a store wins when both enables are set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_wr   <= 1'b0;
      addr_q  <= 17'd0;
      wdata_q <= 32'd0;
    end else if (state == IDLE && req) begin
      op_wr   <= mem_w_en;
      addr_q  <= address[18:2];
      wdata_q <= wdata;
    end
  end

  // Load data capture on the final wait cycle of each half.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= 32'd0;
    end else if (!op_wr && last) begin
      if (state == LOW)  rdata[15:0]  <= sram_dq_in;
      if (state == HIGH) rdata[31:16] <= sram_dq_in;
    end
  end

  // SRAM strobes and bus drive; the last cycle of each half is a write hold.
  always_comb begin
    sram_addr   = 18'd0;
    sram_dq_out = 16'd0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    if (state == LOW || state == HIGH) begin
      sram_addr = {addr_q, half};
      if (op_wr) begin
        sram_dq_oe  = 1'b1;
        sram_dq_out = half ? wdata_q[31:16] : wdata_q[15:0];
        sram_we_n   = last;
      end
    end
  end

  assign freeze = req & (state != DONE);
  assign ready  = (state == DONE);

endmodule
